// File: rtl/base_decode.sv
// base_decode: binary-to-one-hot decoder with an enable gate.
// Bit i of dout is high when en is high and din equals i.
//   en    in   1          decode enable; dout is all-zero when low
//   din   in   enc_width  binary index, MSB at bit 0
//   dout  out  dec_width  one-hot result, bit i for index i
module base_decode #(
  parameter int unsigned enc_width = 2,
  parameter int unsigned dec_width = 2 ** enc_width
) (
  input  logic                 en,
  input  logic [0:enc_width-1] din,
  output logic [0:dec_width-1] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(dec_width); i++) begin
      dout[i] = en & (din == enc_width'(i));
    end
  end

endmodule

// File: rtl/base_rr_encode.sv
// base_rr_encode: registered round-robin encoder. Picks one of dec_width
// request lines, starting the scan at a rotating priority pointer, and
// presents its binary index over a valid/ready handshake.
//   clk       in   1          clock, rising edge
//   reset     in   1          asynchronous, active-high reset
//   en        in   1          capture enable
//   req       in   dec_width  request lines, bit i = source i
//   take      out  dec_width  one-hot capture pulse (combinational)
//   o_v       out  1          output valid (registered)
//   o_r       in   1          consumer ready
//   o_idx     out  enc_width  captured source index (registered), MSB at bit 0
//   o_onehot  out  dec_width  decode of o_idx, gated by o_v
module base_rr_encode #(
  parameter int unsigned enc_width = 2,
  parameter int unsigned dec_width = 2 ** enc_width
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [0:dec_width-1] req,
  output logic [0:dec_width-1] take,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:enc_width-1] o_idx,
  output logic [0:dec_width-1] o_onehot
);

  localparam int unsigned last_idx = dec_width - 1;

  logic [enc_width-1:0] ptr;
  logic [enc_width-1:0] ptr_nxt;
  logic [enc_width-1:0] sel;
  logic                 load;
  logic                 o_v_nxt;
  logic [0:enc_width-1] o_idx_nxt;

  // Wrap-around priority scan: lowest requester at or above p wins,
  // otherwise the lowest requester overall (the wrapped part of the scan).
  function automatic logic [enc_width-1:0] rr_pick(
    input logic [0:dec_width-1] r,
    input logic [enc_width-1:0] p
  );
    logic [enc_width-1:0] hi_sel;
    logic [enc_width-1:0] lo_sel;
    logic                 hi_hit;
    hi_sel = '0;
    lo_sel = '0;
    hi_hit = 1'b0;
    for (int i = int'(dec_width) - 1; i >= 0; i--) begin
      if (r[i]) begin
        lo_sel = enc_width'(i);
        if (i >= int'(p)) begin
          hi_sel = enc_width'(i);
          hi_hit = 1'b1;
        end
      end
    end
    return hi_hit ? hi_sel : lo_sel;
  endfunction

  // Next-state and take pulse; reset suppresses any capture.
  always_comb begin
    sel       = rr_pick(req, ptr);
    load      = ~reset & en & (~o_v | o_r) & (|req);
    o_v_nxt   = o_v;
    o_idx_nxt = o_idx;
    ptr_nxt   = ptr;
    take      = '0;
    for (int i = 0; i < int'(dec_width); i++) begin
      take[i] = load & (sel == enc_width'(i));
    end
    if (load) begin
      o_v_nxt   = 1'b1;
      o_idx_nxt = sel;
      ptr_nxt   = (32'(sel) == last_idx) ? '0 : sel + enc_width'(1);
    end else if (o_v && o_r) begin
      o_v_nxt = 1'b0;
    end
  end

  // Output register and priority pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_v   <= 1'b0;
      o_idx <= '0;
      ptr   <= '0;
    end else begin
      o_v   <= o_v_nxt;
      o_idx <= o_idx_nxt;
      ptr   <= ptr_nxt;
    end
  end

  base_decode #(
    .enc_width(enc_width),
    .dec_width(dec_width)
  ) u_decode (
    .en  (o_v),
    .din (o_idx),
    .dout(o_onehot)
  );

endmodule

// File: tb/tb_base_rr_encode.sv
module tb_base_rr_encode;

  logic       clk;
  logic       reset;
  logic       en4, o_r4, o_v4;
  logic [0:3] req4, take4, oh4;
  logic [0:1] idx4;
  logic       en3, o_r3, o_v3;
  logic [0:2] req3, take3, oh3;
  logic [0:1] idx3;

  int total = 0;
  int bad   = 0;

  base_rr_encode #(.enc_width(2), .dec_width(4)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .req(req4), .take(take4),
    .o_v(o_v4), .o_r(o_r4), .o_idx(idx4), .o_onehot(oh4));

  base_rr_encode #(.enc_width(2), .dec_width(3)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .req(req3), .take(take3),
    .o_v(o_v3), .o_r(o_r3), .o_idx(idx3), .o_onehot(oh3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: source j is bit (n-1-j) of the request value.
  function automatic bit has_req(input int n, input int r, input int j);
    return ((r >> (n - 1 - j)) & 1) == 1;
  endfunction

  function automatic int pick(input int n, input int p, input int r);
    for (int k = 0; k < n; k++) begin
      if (has_req(n, r, (p + k) % n)) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic int onehot(input int n, input int j);
    return (j < 0) ? 0 : (1 << (n - 1 - j));
  endfunction

  logic m_v4 = 1'b0, m_v3 = 1'b0;
  int   m_idx4 = 0, m_idx3 = 0, m_ptr4 = 0, m_ptr3 = 0;

  function automatic bit loads(input bit rst, input bit e, input bit v, input bit rdy, input int r);
    return !rst && e && (!v || rdy) && (r != 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v4 <= 1'b0; m_idx4 <= 0; m_ptr4 <= 0;
      m_v3 <= 1'b0; m_idx3 <= 0; m_ptr3 <= 0;
    end else begin
      if (loads(1'b0, en4, m_v4, o_r4, int'(req4))) begin
        m_v4   <= 1'b1;
        m_idx4 <= pick(4, m_ptr4, int'(req4));
        m_ptr4 <= (pick(4, m_ptr4, int'(req4)) + 1) % 4;
      end else if (m_v4 && o_r4) m_v4 <= 1'b0;
      if (loads(1'b0, en3, m_v3, o_r3, int'(req3))) begin
        m_v3   <= 1'b1;
        m_idx3 <= pick(3, m_ptr3, int'(req3));
        m_ptr3 <= (pick(3, m_ptr3, int'(req3)) + 1) % 3;
      end else if (m_v3 && o_r3) m_v3 <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int e4, e3;
    e4 = loads(reset, en4, m_v4, o_r4, int'(req4)) ? onehot(4, pick(4, m_ptr4, int'(req4))) : 0;
    e3 = loads(reset, en3, m_v3, o_r3, int'(req3)) ? onehot(3, pick(3, m_ptr3, int'(req3))) : 0;
    check("m4_take", 32'(take4), 32'(e4));
    check("m4_v",    32'(o_v4),  32'(m_v4));
    check("m4_idx",  32'(idx4),  32'(m_idx4));
    check("m4_oh",   32'(oh4),   32'(m_v4 ? onehot(4, m_idx4) : 0));
    check("m3_take", 32'(take3), 32'(e3));
    check("m3_v",    32'(o_v3),  32'(m_v3));
    check("m3_idx",  32'(idx3),  32'(m_idx3));
    check("m3_oh",   32'(oh3),   32'(m_v3 ? onehot(3, m_idx3) : 0));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [0:3] rr_take [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  int         rr_idx  [5] = '{0, 1, 2, 3, 0};
  logic [0:2] n3_take [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
  int         n3_idx  [4] = '{0, 1, 2, 0};

  initial begin
    reset = 1'b0;
    en4 = 1'b1; req4 = 4'b1111; o_r4 = 1'b1;
    en3 = 1'b1; req3 = 3'b000;  o_r3 = 1'b1;
    #1 reset = 1'b1;

    // Reset with all requests high
    repeat (2) @(posedge clk);
    #2;
    check("rst_v",    32'(o_v4),  32'(0));
    check("rst_idx",  32'(idx4),  32'(0));
    check("rst_take", 32'(take4), 32'(0));
    check("rst_oh",   32'(oh4),   32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // Round-robin over all four sources
    for (int k = 0; k < 5; k++) begin
      check("rr_take", 32'(take4), 32'(rr_take[k]));
      tick();
      check("rr_idx", 32'(idx4), 32'(rr_idx[k]));
      check("rr_v",   32'(o_v4), 32'(1));
    end

    // Two more loads bring o_idx to 2, ptr to 3; then backpressure
    tick();
    tick();
    check("bp_pre_idx", 32'(idx4), 32'(2));
    o_r4 = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_take", 32'(take4), 32'(0));
      tick();
      check("bp_idx", 32'(idx4), 32'(2));
      check("bp_v",   32'(o_v4), 32'(1));
    end
    o_r4 = 1'b1;
    #1;
    check("bp_rel_take", 32'(take4), 32'(4'b0001));
    tick();
    check("bp_rel_idx", 32'(idx4), 32'(3));

    // Sparse wrap: set ptr to 3 via source 2, then scan wraps to source 1
    req4 = 4'b0010;
    tick();
    check("sp_idx2", 32'(idx4), 32'(2));
    req4 = 4'b0100;
    #1;
    check("sp_take", 32'(take4), 32'(4'b0100));
    tick();
    check("sp_idx1", 32'(idx4), 32'(1));
    req4 = 4'b1001;
    #1;
    check("sp_take3", 32'(take4), 32'(4'b0001));
    tick();
    check("sp_idx3", 32'(idx4), 32'(3));

    // Drain with no requests
    req4 = 4'b0000;
    tick();
    check("dr_v",  32'(o_v4), 32'(0));
    check("dr_oh", 32'(oh4),  32'(0));

    // Enable gating
    req4 = 4'b1111;
    tick();
    check("en_idx0", 32'(idx4), 32'(0));
    en4 = 1'b0;
    #1;
    check("en_off_take", 32'(take4), 32'(0));
    tick();
    check("en_off_v", 32'(o_v4), 32'(0));
    en4 = 1'b1;
    #1;
    check("en_on_take", 32'(take4), 32'(4'b0100));
    tick();
    check("en_on_idx", 32'(idx4), 32'(1));
    check("en_on_oh",  32'(oh4),  32'(4'b0100));

    // Three-source instance: wrap at 3, index 3 never produced
    req4 = 4'b0000;
    req3 = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("n3_take", 32'(take3), 32'(n3_take[k]));
      tick();
      check("n3_idx", 32'(idx3), 32'(n3_idx[k]));
      check("n3_v",   32'(o_v3), 32'(1));
    end

    // Asynchronous reset mid-cycle drops valid immediately
    #1 reset = 1'b1;
    #1;
    check("arst_v3",  32'(o_v3),  32'(0));
    check("arst_v4",  32'(o_v4),  32'(0));
    check("arst_tk3", 32'(take3), 32'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    req3 = 3'b000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/base_rr_encode.md
Name: base_rr_encode

Overview:
- Registered round-robin encoder, the inverse of the team's one-hot decoder.
- Takes a vector of request lines and emits the binary index of one selected requester over a valid/ready handshake.
- Each captured requester gets a one-cycle take pulse.
- Sits in front of shared resources (mux selects, table ports) where N sources contend and the consumer wants an encoded index.

Parameters:
- enc_width, 2, width of the encoded index output.
- dec_width, 2**enc_width, number of request lines; legal range 2..2**enc_width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when 0, no new request is captured; a held output is unaffected.
- req  input  [0:dec_width-1]  request lines; bit i means source i requests.
- take  output  [0:dec_width-1]  one-hot pulse; bit i is high in the cycle source i is captured. Combinational from req, en and state.
- o_v  output  1  output index valid (registered).
- o_r  input  1  consumer ready.
- o_idx  output  [0:enc_width-1]  encoded index of the captured source (registered), MSB at bit 0.
- o_onehot  output  [0:dec_width-1]  one-hot form of o_idx, gated by o_v.

Behaviour:
- Reset (asynchronous):
  - o_v=0, o_idx=0, ptr=0.
  - take and o_onehot are 0 while reset is high.
- State:
  - Output register {o_v, o_idx}.
  - Priority pointer ptr, range 0..dec_width-1.
- load = en & (~o_v | o_r) & (|req).
- Selection: sel is the first i with req[i]=1, scanning ptr, ptr+1, …, dec_width-1, 0, …, ptr-1. Wrap is at dec_width, not at 2**enc_width.
- On load:
  - o_v<=1, o_idx<=sel.
  - ptr<=sel+1, or 0 when sel=dec_width-1.
  - take[sel]=1 in the same cycle; all other take bits are 0.
- Output accepted with no load (o_v & o_r & ~load): o_v<=0; o_idx and ptr hold.
- o_v=1 and o_r=0: o_idx, o_v and ptr hold; take=0 regardless of req. There is no overwrite.
- Accept and load in the same cycle: the new index replaces the old one, giving back-to-back throughput of one index per cycle.
- Latency: req to o_v is 1 cycle.
- Fairness: a continuously asserted request is captured within dec_width loads.
- Requesters must drop req the cycle after their take pulse, or they will be reselected on the next round-robin turn.
- A req bit that is high only in a cycle where load=0 is not remembered.
- en=0 with o_v=1 and o_r=1: the output drains and o_v goes to 0.
- Reset mid-transfer: o_v drops immediately; the pending index is lost, and the consumer must treat it as never sent.
- o_onehot equals en-independent decode(o_idx) & o_v.

Decomposition:
- No shared package is needed; the only constant is dec_width, derived locally.
- One sub-module: the team's existing base_decode, instantiated with en=o_v and din=o_idx, produces o_onehot.
- The wrap-around priority scan is a local function or generate loop, not a separate module.

Test Plan (enc_width=2, dec_width=4):
- Reset: assert reset with req=4'b1111 → o_v=0, o_idx=0, take=0 while reset is high; after release, first load selects index 0.
- Round-robin: req=1111, o_r=1, en=1 held for 5 cycles → o_idx sequence 0,1,2,3,0; take pulses 1000,0100,0010,0001,1000; o_v stays 1.
- Backpressure: o_v=1, o_idx=2, o_r=0 for 3 cycles with req=1111 → o_idx stays 2, take=0, ptr unchanged; then o_r=1 → next o_idx=3.
- Sparse wrap: ptr=3, req=0100 → o_idx=1, take=0100, ptr becomes 2; next req=1001 → o_idx=3.
- Non-power-of-2 (enc_width=2, dec_width=3): req=111 for 4 loads → o_idx 0,1,2,0; index 3 never appears.
- Enable gating: en=0 with req=1111, o_v=1, o_r=1 → o_v falls next cycle, take stays 0; en=1 → capture resumes from ptr.
